// File: rtl/bob_ring_if.sv
// Bus bundle for bob_ring_ctrl: allocate, retire, status and payload-port signals.
// The master side drives requests and payload accesses; the slave side is the
// ring controller itself.
// Optional macro BOB_RING_PARITY_EN adds the rd_perr status signal.
// Handshake rules:
//  - alloc_req/alloc_ok: alloc_ok is a same-cycle combinational grant. A request is
//    taken at the next clock edge only when alloc_ok is high, and it is all-or-nothing.
//  - retire_req/retire_cnt: retire_cnt is the number of entries actually consumed
//    at the next clock edge.
interface bob_ring_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 7,
  parameter int AREQ_W = 3,
  parameter int RREQ_W = 3
);
  logic              except;
  logic [AREQ_W-1:0] alloc_req;
  logic              alloc_stall;
  logic [ADDR_W-1:0] alloc_base;
  logic              alloc_ok;
  logic [RREQ_W-1:0] retire_req;
  logic [RREQ_W-1:0] retire_cnt;
  logic [ADDR_W-1:0] head;
  logic [CNT_W-1:0]  occ;
  logic [CNT_W-1:0]  free;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
`ifdef BOB_RING_PARITY_EN
  logic              rd_perr;
`endif

  modport master (
    output except, alloc_req, alloc_stall, retire_req,
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
`ifdef BOB_RING_PARITY_EN
    input  rd_perr,
`endif
    input  alloc_base, alloc_ok, retire_cnt, head, occ, free, rd_data
  );

  modport slave (
    input  except, alloc_req, alloc_stall, retire_req,
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
`ifdef BOB_RING_PARITY_EN
    output rd_perr,
`endif
    output alloc_base, alloc_ok, retire_cnt, head, occ, free, rd_data
  );
endinterface

// File: rtl/bob_ring_ctrl.sv
// Circular-buffer controller with payload storage for back-end ordered buffers.
// Allocates up to ALLOC_W entries at the tail and retires up to RETIRE_W entries
// at the head each cycle; any DEPTH is supported with exact modulo wrap.
// An exception flushes all live entries. Payload is read through a registered
// read address.
// Optional macro BOB_RING_PARITY_EN: stores an even-parity bit per entry and
// drives rd_perr.
module bob_ring_ctrl #(
  parameter int DEPTH    = 63,
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 64,
  parameter int ALLOC_W  = 4,
  parameter int RETIRE_W = 4,
  parameter int CNT_W    = 7
) (
  input  logic     clk,
  input  logic     rst,
  bob_ring_if.slave bus
);
  localparam int AREQ_W  = $clog2(ALLOC_W + 1);
  localparam int RREQ_W  = $clog2(RETIRE_W + 1);
  localparam int SLICE_W = DATA_W / 4;
  localparam logic [ADDR_W:0]  DEPTH_A = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] head_q, tail_q, rd_addr_q;
  logic [CNT_W-1:0]  occ_q, free_c;
  logic              alloc_ok_c;
  logic [RREQ_W-1:0] retire_cnt_c;
  logic              wr_ok;

  // Index advance: plain sum followed by one conditional subtract of DEPTH.
  // This works because inc never exceeds DEPTH.
  function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] base,
                                                 input logic [ADDR_W:0]   inc);
    logic [ADDR_W:0] sum;
    sum = {1'b0, base} + inc;
    if (sum >= DEPTH_A) sum = sum - DEPTH_A;
    return sum[ADDR_W-1:0];
  endfunction

  assign free_c         = DEPTH_C - occ_q;
  assign bus.alloc_base = tail_q;
  assign bus.head       = head_q;
  assign bus.occ        = occ_q;
  assign bus.free       = free_c;
  assign bus.alloc_ok   = alloc_ok_c;
  assign bus.retire_cnt = retire_cnt_c;
  assign wr_ok          = bus.wr_en && ((ADDR_W + 1)'(bus.wr_addr) < DEPTH_A);

  // Grant the whole allocation only when it fits in the current free space.
  // Retires in the same cycle are not credited.
  always_comb begin
    alloc_ok_c = 1'b0;
    if (!bus.except && !bus.alloc_stall && (bus.alloc_req != '0) &&
        (CNT_W'(bus.alloc_req) <= free_c))
      alloc_ok_c = 1'b1;
  end

  // Clip the retire request to the number of live entries.
  // Nothing retires during a flush.
  always_comb begin
    retire_cnt_c = '0;
    if (!bus.except)
      retire_cnt_c = (CNT_W'(bus.retire_req) > occ_q) ? RREQ_W'(occ_q) : bus.retire_req;
  end

  // Ring pointers and occupancy.
  // A flush collapses head onto the pre-update tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else if (bus.except) begin
      head_q <= tail_q;
      occ_q  <= '0;
    end else begin
      if (alloc_ok_c) tail_q <= wrap_add(tail_q, (ADDR_W + 1)'(bus.alloc_req));
      head_q <= wrap_add(head_q, (ADDR_W + 1)'(retire_cnt_c));
      occ_q  <= occ_q + (alloc_ok_c ? CNT_W'(bus.alloc_req) : '0) - CNT_W'(retire_cnt_c);
    end
  end

  // Registered read address for the payload array.
  always_ff @(posedge clk) begin
    if (rst)             rd_addr_q <= '0;
    else if (bus.rd_en)  rd_addr_q <= bus.rd_addr;
  end

  // Payload storage split into four column slices; the last slice takes the
  // remainder bits.
  for (genvar s = 0; s < 4; s++) begin : g_col
    localparam int LO = s * SLICE_W;
    localparam int SW = (s == 3) ? (DATA_W - 3 * SLICE_W) : SLICE_W;
    logic [SW-1:0] col [DEPTH];
    logic [SW-1:0] rd_col;
    // Column write; out-of-range indices are dropped.
    always_ff @(posedge clk) begin
      if (wr_ok) col[bus.wr_addr] <= bus.wr_data[LO +: SW];
    end
    assign rd_col = col[rd_addr_q];
  end

  assign bus.rd_data = {g_col[3].rd_col, g_col[2].rd_col, g_col[1].rd_col, g_col[0].rd_col};

`ifdef BOB_RING_PARITY_EN
  logic             par_mem [DEPTH];
  logic [DEPTH-1:0] written_q;
  logic             rd_in_range;

  assign rd_in_range = (ADDR_W + 1)'(rd_addr_q) < DEPTH_A;

  // Store the parity bit at write time.
  always_ff @(posedge clk) begin
    if (wr_ok) par_mem[bus.wr_addr] <= ^bus.wr_data;
  end

  // Track written entries so rd_perr stays quiet on never-written storage.
  always_ff @(posedge clk) begin
    if (rst)        written_q <= '0;
    else if (wr_ok) written_q[bus.wr_addr] <= 1'b1;
  end

  assign bus.rd_perr = rd_in_range && written_q[rd_addr_q] &&
                       ((^bus.rd_data) != par_mem[rd_addr_q]);
`endif
endmodule

// File: doc/bob_ring_ctrl.md
Name: bob_ring_ctrl

Overview:
Parametrised circular-buffer controller with integrated payload storage for back-end ordered buffers.
- Allocates up to ALLOC_W consecutive entries per cycle at the tail.
- Retires up to RETIRE_W entries per cycle from the head.
- Supports any DEPTH, including non-power-of-two, with exact modulo wrap.
- On exception, flushes all in-flight entries. Sits between rename/allocate and retire logic; payload is read back by retire with a registered-address read.

Parameters:
DEPTH, 63, number of entries; any value 2..1024
ADDR_W, 6, index width; must satisfy 2^ADDR_W >= DEPTH
DATA_W, 64, payload bits per entry
ALLOC_W, 4, max entries allocated per cycle
RETIRE_W, 4, max entries retired per cycle
CNT_W, 7, occupancy counter width; must hold DEPTH

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
except  in  1  flush all live entries
alloc_req  in  clog2(ALLOC_W+1)  entries requested this cycle
alloc_stall  in  1  external stall; suppresses allocation
alloc_base  out  ADDR_W  index of first allocated entry (current tail)
alloc_ok  out  1  request granted this cycle
retire_req  in  clog2(RETIRE_W+1)  entries to retire this cycle
retire_cnt  out  clog2(RETIRE_W+1)  entries actually retired this cycle
head  out  ADDR_W  current head index
occ  out  CNT_W  live entry count
free  out  CNT_W  DEPTH-occ
wr_en  in  1  payload write enable
wr_addr  in  ADDR_W  payload write index
wr_data  in  DATA_W  payload
rd_en  in  1  capture read address
rd_addr  in  ADDR_W  payload read index
rd_data  out  DATA_W  payload at registered read address

Behaviour:
- Reset (rst high at posedge): head=0, tail=0, occ=0, read-address register=0. Therefore alloc_base=0 and free=DEPTH. Array contents are undefined. rst has priority over all other inputs.
- Combinational outputs:
  - alloc_ok = !alloc_stall && alloc_req!=0 && alloc_req<=free. Same-cycle retires are not credited.
  - retire_cnt = min(retire_req, occ). Requests beyond occ are clipped, never wrap.
- Allocation: if alloc_ok, tail <= (tail+alloc_req) mod DEPTH. The granted indices are alloc_base..alloc_base+alloc_req-1, mod DEPTH. If the grant would overflow, the whole request is rejected (all-or-nothing) and tail is unchanged.
- Retire: head <= (head+retire_cnt) mod DEPTH.
- Counter: occ <= occ + (alloc_ok ? alloc_req : 0) - retire_cnt. Allocate and retire in the same cycle are both applied.
- Wrap: indices are computed as a sum with a conditional subtract of DEPTH. Index DEPTH-1 wraps to 0; no index >= DEPTH ever appears.
- except (rst low):
  - head <= tail, using the tail value before this cycle's update; occ <= 0.
  - Allocation and retire in the same cycle are ignored; alloc_ok and retire_cnt read 0 while except is high.
  - Payload writes still complete.
- Full/empty:
  - occ==DEPTH: every nonzero alloc_req is denied.
  - occ==0: retire_cnt=0.
- Payload array:
  - Write: one write port; on posedge with wr_en, ram[wr_addr] <= wr_data.
  - Read address: on posedge with rd_en, the read-address register <= rd_addr.
  - Read data: rd_data = ram[read-address register], combinational from the register.
  - Write to the held read address: the new value appears on rd_data the cycle after the write.
- Array storage: the array is built as four column slices, each DATA_W/4 wide, with the remainder bits in the last slice.
- Out-of-range indices: wr_addr >= DEPTH is ignored.

Optional Feature:
Macro BOB_RING_PARITY_EN.
- Defined:
  - Each entry stores one even-parity bit over wr_data, computed at write.
  - Extra output rd_perr (1 bit) is high when the recomputed parity of rd_data mismatches the stored bit.
  - rd_perr is 0 after reset until the first rd_en capture of a written entry.
- Undefined: no parity storage and no rd_perr port; all other behaviour is identical.

Test Plan:
Defaults (DEPTH=63, ALLOC_W=4). After reset, alloc_req=4 on each of 15 cycles -> alloc_base 0,4,...,56; occ=60, free=3. Next alloc_req=4 -> alloc_ok=0, tail stays 60. Then alloc_req=3 -> alloc_ok=1, tail wraps to 0, occ=63.
Wrap: head=61, occ=5, retire_req=4 -> retire_cnt=4, head=2, occ=1. Next retire_req=4 -> retire_cnt=1, head=3, occ=0.
Simultaneous: occ=63, retire_req=2 and alloc_req=2 in the same cycle -> alloc_ok=0 (no credit), occ=61. Next cycle alloc_req=2 -> alloc_ok=1, occ=63.
Flush: tail=17, head=5, occ=12, except with alloc_req=3 and retire_req=2 -> alloc_ok=0, retire_cnt=0. Next cycle: head=17, occ=0, alloc_base=17.
Payload: write 0xDEAD_BEEF_0123_4567 to index 62; rd_en with rd_addr=62 -> rd_data equals that value next cycle. Write 0x1 to 62 while rd_en=0 -> rd_data=0x1 the following cycle.
Reset mid-operation: occ=40 and except=1 together with rst=1 -> head=0, tail=0, occ=0, free=63. With BOB_RING_PARITY_EN, rd_perr=0.
